kmeans_iteration_ctrl: RTL

Top-level sequencer for one K-means clustering run over a frame. It clears the per-cluster RGB accumulators and streams every frame pixel through the assignment/accumulation stage. It then drives the 16-cluster, three-channel mean divider and scans the new means against the current centroids to detect convergence. Finally it commits the new means and repeats until the centroids converge or the iteration limit is reached.

---
 rtl/kmeans_iteration_ctrl_if.sv | 33 +++
 rtl/kmeans_iteration_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/kmeans_iteration_ctrl_if.sv
// Pixel stream, divider and compare-mux signals between the K-means sequencer (master)
// and its datapath (slave).
interface kmeans_iteration_ctrl_if #(
  parameter int MEAN_W = 8
);
  logic              pix_valid;
  logic              pix_ready;
  logic              accum_en;
  logic              accum_clr;
  logic [15:0]       nonempty;
  logic              div_ce;
  logic              div_clr;
  logic [15:0]       div_en;
  logic              div_ready;
  logic [3:0]        cmp_idx;
  logic [MEAN_W-1:0] new_r;
  logic [MEAN_W-1:0] new_g;
  logic [MEAN_W-1:0] new_b;
  logic [MEAN_W-1:0] old_r;
  logic [MEAN_W-1:0] old_g;
  logic [MEAN_W-1:0] old_b;
  logic              load_means;

  modport master (
    input  pix_valid, nonempty, div_ready, new_r, new_g, new_b, old_r, old_g, old_b,
    output pix_ready, accum_en, accum_clr, div_ce, div_clr, div_en, cmp_idx, load_means
  );

  modport slave (
    output pix_valid, nonempty, div_ready, new_r, new_g, new_b, old_r, old_g, old_b,
    input  pix_ready, accum_en, accum_clr, div_ce, div_clr, div_en, cmp_idx, load_means
  );
endinterface

// File: rtl/kmeans_iteration_ctrl.sv
// K-means run sequencer: clear, accumulate a frame, divide, compare 16 clusters, commit, repeat.
// Moore control outputs (accum_en is pix_valid & pix_ready); pixels only accepted in ACCUM.
module kmeans_iteration_ctrl #(
  parameter int NUM_PIXELS  = 76800,
  parameter int PIX_CNT_W   = 17,
  parameter int ACC_LAT     = 2,
  parameter int MEAN_W      = 8,
  parameter int THRESH      = 1,
  parameter int MAX_ITER    = 16,
  parameter int ITER_W      = 5,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  kmeans_iteration_ctrl_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic                    timeout_err,
  output logic [ITER_W-1:0]       iter
);

  localparam int CNT_MAX = (DIV_TIMEOUT > 16) ?
                           ((DIV_TIMEOUT > ACC_LAT) ? DIV_TIMEOUT : ACC_LAT) :
                           ((ACC_LAT > 16) ? ACC_LAT : 16);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int DW    = MEAN_W + 1;
  localparam logic [DW-1:0] THR = DW'(THRESH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DIVIDE, S_COMPARE, S_UPDATE, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0]     cnt;
  logic                 changed;
  logic [15:0]          div_en_q;

  logic pix_ready, accum_en, accum_clr, div_ce, div_clr, load_means;
  logic last_pix, drain_end, div_go, div_tmo, cmp_last, iter_limit, clus_changed;
  logic [DW-1:0] d_r, d_g, d_b;

  function automatic logic [DW-1:0] absdiff(input logic [MEAN_W-1:0] a,
                                            input logic [MEAN_W-1:0] b);
    absdiff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  assign last_pix   = accum_en && (pix_cnt == PIX_CNT_W'(NUM_PIXELS - 1));
  assign drain_end  = (cnt == CNT_W'(ACC_LAT - 1));
  // div_ready is ignored on the divider's restart cycle
  assign div_go     = (cnt != '0) && bus.div_ready;
  assign div_tmo    = (cnt == CNT_W'(DIV_TIMEOUT - 1));
  assign cmp_last   = (cnt[3:0] == 4'd15);
  assign iter_limit = ((32'(iter) + 32'd1) == 32'(MAX_ITER));

  assign d_r = absdiff(bus.new_r, bus.old_r);
  assign d_g = absdiff(bus.new_g, bus.old_g);
  assign d_b = absdiff(bus.new_b, bus.old_b);
  assign clus_changed = div_en_q[cnt[3:0]] && ((d_r > THR) || (d_g > THR) || (d_b > THR));

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    accum_clr  = 1'b0;
    div_ce     = 1'b0;
    div_clr    = 1'b0;
    load_means = 1'b0;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        accum_clr = 1'b1;
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        pix_ready = 1'b1;
        if (last_pix) state_nxt = (ACC_LAT == 0) ? S_DIVIDE : S_DRAIN;
      end
      S_DRAIN:   if (drain_end) state_nxt = S_DIVIDE;
      S_DIVIDE: begin
        div_ce  = 1'b1;
        div_clr = (cnt == '0);
        if (div_go)       state_nxt = S_COMPARE;
        else if (div_tmo) state_nxt = S_DONE;
      end
      S_COMPARE: if (cmp_last) state_nxt = S_UPDATE;
      S_UPDATE: begin
        load_means = 1'b1;
        state_nxt  = (!changed || iter_limit) ? S_DONE : S_CLEAR;
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    accum_en = bus.pix_valid & pix_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_cnt     <= '0;
      cnt         <= '0;
      changed     <= 1'b0;
      div_en_q    <= '0;
      iter        <= '0;
      converged   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          iter        <= '0;
          converged   <= 1'b0;
          timeout_err <= 1'b0;
        end
        S_CLEAR: begin
          pix_cnt <= '0;
          cnt     <= '0;
          changed <= 1'b0;
        end
        S_ACCUM: begin
          cnt <= '0;
          if (accum_en) pix_cnt <= pix_cnt + 1'b1;
        end
        S_DRAIN: cnt <= drain_end ? '0 : cnt + 1'b1;
        S_DIVIDE: begin
          if (cnt == '0) div_en_q <= bus.nonempty;
          if (div_go) begin
            cnt <= '0;
          end else if (div_tmo) begin
            timeout_err <= 1'b1;
            converged   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_COMPARE: begin
          if (clus_changed) changed <= 1'b1;
          cnt <= cmp_last ? '0 : cnt + 1'b1;
        end
        S_UPDATE: begin
          if (iter != '1) iter <= iter + 1'b1;
          if (!changed)        converged <= 1'b1;
          else if (iter_limit) converged <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.accum_en   = accum_en;
  assign bus.accum_clr  = accum_clr;
  assign bus.div_ce     = div_ce;
  assign bus.div_clr    = div_clr;
  assign bus.div_en     = div_en_q;
  assign bus.cmp_idx    = (state == S_COMPARE) ? cnt[3:0] : 4'd0;
  assign bus.load_means = load_means;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

endmodule
